// File: rtl/if_stage_if.sv
// Fetch-stage boundary: decode handshake, branch bus and
// instruction SRAM port grouped into one bundle.
interface if_stage_if;
   logic        ID_Allow_in;
   logic [32:0] br_bus;
   logic        IF_to_ID_Valid;
   logic [63:0] IF_to_ID_Bus;
   logic        inst_sram_en;
   logic [3:0]  inst_sram_we;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;
   logic [31:0] inst_sram_rdata;

   modport master (
      input  ID_Allow_in,
      input  br_bus,
      input  inst_sram_rdata,
      output IF_to_ID_Valid,
      output IF_to_ID_Bus,
      output inst_sram_en,
      output inst_sram_we,
      output inst_sram_addr,
      output inst_sram_wdata
   );

   modport slave (
      output ID_Allow_in,
      output br_bus,
      output inst_sram_rdata,
      input  IF_to_ID_Valid,
      input  IF_to_ID_Bus,
      input  inst_sram_en,
      input  inst_sram_we,
      input  inst_sram_addr,
      input  inst_sram_wdata
   );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: pc sequencing, branch redirect and a
// one-entry buffer that holds SRAM read data across decode stalls.
module if_stage (
   input  logic         clk,
   input  logic         reset,
   if_stage_if.master   bus
);
   localparam logic [31:0] RESET_PC = 32'h1bfffffc;

   logic        w_to_if_valid;
   logic        w_br_taken;
   logic [31:0] w_br_target;
   logic [31:0] w_seq_pc;
   logic [31:0] w_nextpc;
   logic        w_if_ready_go;
   logic        w_if_allow_in;
   logic [31:0] w_inst;

   logic        r_if_valid;
   logic [31:0] r_if_pc;
   logic        r_buf_valid;
   logic [31:0] r_inst_buf;

   assign w_to_if_valid = ~reset;
   assign w_br_taken    = bus.br_bus[32];
   assign w_br_target   = bus.br_bus[31:0];
   assign w_seq_pc      = r_if_pc + 32'd4;
   assign w_nextpc      = w_br_taken ? w_br_target : w_seq_pc;
   assign w_if_ready_go = 1'b1;
   assign w_if_allow_in = ~r_if_valid
                        | (w_if_ready_go & bus.ID_Allow_in);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_if_valid <= 1'b0;
         r_if_pc    <= RESET_PC;
      end else if (w_if_allow_in) begin
         r_if_valid <= w_to_if_valid;
         r_if_pc    <= w_nextpc;
      end
   end

   // SRAM data is only guaranteed the cycle after the read, so
   // capture it on the first stall cycle and replay it afterwards.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_buf_valid <= 1'b0;
         r_inst_buf  <= 32'h0;
      end else if (w_if_allow_in) begin
         r_buf_valid <= 1'b0;
      end else if (r_if_valid & ~bus.ID_Allow_in & ~r_buf_valid) begin
         r_buf_valid <= 1'b1;
         r_inst_buf  <= bus.inst_sram_rdata;
      end
   end

   assign w_inst = r_buf_valid ? r_inst_buf : bus.inst_sram_rdata;

   assign bus.IF_to_ID_Valid  = r_if_valid & w_if_ready_go & ~w_br_taken;
   assign bus.IF_to_ID_Bus    = {r_if_pc, w_inst};
   assign bus.inst_sram_en    = w_to_if_valid & w_if_allow_in;
   assign bus.inst_sram_we    = 4'h0;
   assign bus.inst_sram_addr  = w_nextpc;
   assign bus.inst_sram_wdata = 32'h0;
endmodule

// File: tb/tb_if_stage.sv
// Directed checks of fetch sequencing, stall buffering,
// branch redirect and reset recovery.
module tb_if_stage;
   logic clk;
   logic reset;
   int   n_chk;
   int   n_err;

   if_stage_if bus ();

   if_stage dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      reset = 1'b1;
      bus.ID_Allow_in     = 1'b1;
      bus.br_bus          = 33'h0;
      bus.inst_sram_rdata = 32'h0;
      tick();
      tick();
      settle();
      chk("rst_valid", 64'(bus.IF_to_ID_Valid), 64'd0);
      chk("rst_en", 64'(bus.inst_sram_en), 64'd0);
      chk("rst_bus", bus.IF_to_ID_Bus, {32'h1bfffffc, 32'h0});
      chk("we", 64'(bus.inst_sram_we), 64'd0);
      chk("wdata", 64'(bus.inst_sram_wdata), 64'd0);

      reset = 1'b0;
      settle();
      chk("c0_en", 64'(bus.inst_sram_en), 64'd1);
      chk("c0_addr", 64'(bus.inst_sram_addr), 64'h1c000000);
      chk("c0_valid", 64'(bus.IF_to_ID_Valid), 64'd0);

      tick();
      bus.inst_sram_rdata = 32'h02800421;
      settle();
      chk("c1_valid", 64'(bus.IF_to_ID_Valid), 64'd1);
      chk("c1_bus", bus.IF_to_ID_Bus, {32'h1c000000, 32'h02800421});
      chk("c1_addr", 64'(bus.inst_sram_addr), 64'h1c000004);

      tick();
      bus.inst_sram_rdata = 32'h00000013;
      settle();
      chk("c2_bus", bus.IF_to_ID_Bus, {32'h1c000004, 32'h00000013});
      chk("c2_addr", 64'(bus.inst_sram_addr), 64'h1c000008);

      tick();
      bus.inst_sram_rdata = 32'h00150004;
      bus.ID_Allow_in = 1'b0;
      settle();
      chk("s1_en", 64'(bus.inst_sram_en), 64'd0);
      chk("s1_bus", bus.IF_to_ID_Bus, {32'h1c000008, 32'h00150004});
      chk("s1_valid", 64'(bus.IF_to_ID_Valid), 64'd1);

      tick();
      bus.inst_sram_rdata = 32'hdeadbeef;
      settle();
      chk("s2_en", 64'(bus.inst_sram_en), 64'd0);
      chk("s2_bus", bus.IF_to_ID_Bus, {32'h1c000008, 32'h00150004});

      tick();
      settle();
      chk("s3_en", 64'(bus.inst_sram_en), 64'd0);
      chk("s3_bus", bus.IF_to_ID_Bus, {32'h1c000008, 32'h00150004});

      tick();
      bus.ID_Allow_in = 1'b1;
      settle();
      chk("rel_en", 64'(bus.inst_sram_en), 64'd1);
      chk("rel_addr", 64'(bus.inst_sram_addr), 64'h1c00000c);
      chk("rel_bus", bus.IF_to_ID_Bus, {32'h1c000008, 32'h00150004});

      tick();
      bus.inst_sram_rdata = 32'h11111111;
      settle();
      chk("c5_bus", bus.IF_to_ID_Bus, {32'h1c00000c, 32'h11111111});
      chk("c5_addr", 64'(bus.inst_sram_addr), 64'h1c000010);

      tick();
      bus.inst_sram_rdata = 32'h22222222;
      bus.br_bus = {1'b1, 32'h1c000100};
      settle();
      chk("br_valid", 64'(bus.IF_to_ID_Valid), 64'd0);
      chk("br_addr", 64'(bus.inst_sram_addr), 64'h1c000100);
      chk("br_en", 64'(bus.inst_sram_en), 64'd1);

      tick();
      bus.br_bus = 33'h0;
      bus.inst_sram_rdata = 32'h33333333;
      settle();
      chk("tgt_valid", 64'(bus.IF_to_ID_Valid), 64'd1);
      chk("tgt_bus", bus.IF_to_ID_Bus, {32'h1c000100, 32'h33333333});

      bus.ID_Allow_in = 1'b0;
      bus.br_bus = {1'b1, 32'h1c000200};
      settle();
      chk("bs1_en", 64'(bus.inst_sram_en), 64'd0);
      chk("bs1_valid", 64'(bus.IF_to_ID_Valid), 64'd0);

      tick();
      settle();
      chk("bs2_en", 64'(bus.inst_sram_en), 64'd0);
      chk("bs2_pc", 64'(bus.IF_to_ID_Bus[63:32]), 64'h1c000100);

      tick();
      bus.ID_Allow_in = 1'b1;
      settle();
      chk("bsr_en", 64'(bus.inst_sram_en), 64'd1);
      chk("bsr_addr", 64'(bus.inst_sram_addr), 64'h1c000200);
      chk("bsr_valid", 64'(bus.IF_to_ID_Valid), 64'd0);

      tick();
      bus.br_bus = 33'h0;
      bus.inst_sram_rdata = 32'h44444444;
      settle();
      chk("bst_valid", 64'(bus.IF_to_ID_Valid), 64'd1);
      chk("bst_bus", bus.IF_to_ID_Bus, {32'h1c000200, 32'h44444444});

      bus.ID_Allow_in = 1'b0;
      tick();
      bus.inst_sram_rdata = 32'h55555555;
      settle();
      chk("buf_hold", bus.IF_to_ID_Bus, {32'h1c000200, 32'h44444444});

      reset = 1'b1;
      tick();
      settle();
      chk("mr_valid", 64'(bus.IF_to_ID_Valid), 64'd0);
      chk("mr_bus", bus.IF_to_ID_Bus, {32'h1bfffffc, 32'h55555555});
      chk("mr_en", 64'(bus.inst_sram_en), 64'd0);

      reset = 1'b0;
      bus.ID_Allow_in = 1'b1;
      settle();
      chk("mr_rel_en", 64'(bus.inst_sram_en), 64'd1);
      chk("mr_rel_addr", 64'(bus.inst_sram_addr), 64'h1c000000);

      bus.br_bus = {1'b1, 32'hfffffffc};
      tick();
      bus.br_bus = 33'h0;
      settle();
      chk("wrap_pc", 64'(bus.IF_to_ID_Bus[63:32]), 64'hfffffffc);
      chk("wrap_addr", 64'(bus.inst_sram_addr), 64'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 ID_Allow_in  input  1  decode stage can accept an instruction this cycle.
REQ-004 br_bus  input  33  {br_taken[32], br_target[31:0]}; br_taken asserted by decode for a valid taken branch or jump.
REQ-005 IF_to_ID_Valid  output  1  IF_to_ID_Bus carries a valid, correct-path instruction.
REQ-006 IF_to_ID_Bus  output  64  {pc[63:32], inst[31:0]}.
REQ-007 inst_sram_en  output  1  instruction SRAM read enable.
REQ-008 inst_sram_we  output  4  byte write enables; constant 4'h0.
REQ-009 inst_sram_addr  output  32  fetch byte address.
REQ-010 inst_sram_wdata  output  32  constant 32'h0.
REQ-011 inst_sram_rdata  input  32  read data, valid one cycle after an enabled read.

Function
REQ-012 Pre-IF valid (to_IF_Valid) SHALL be ~reset.
REQ-013 seq_pc SHALL be IF_pc + 32'd4, with 32-bit wrap-around and no carry-out.
REQ-014 nextpc SHALL be br_target when br_taken=1, else seq_pc.
REQ-015 IF_ReadyGo SHALL be constant 1.
REQ-016 IF_Allow_in SHALL be !IF_Valid || (IF_ReadyGo && ID_Allow_in).
REQ-017 inst_sram_en SHALL be to_IF_Valid && IF_Allow_in.
REQ-018 inst_sram_addr SHALL equal nextpc every cycle.
REQ-019 When IF_Allow_in=1, IF_Valid SHALL load to_IF_Valid and IF_pc SHALL load nextpc. Otherwise both SHALL hold.
REQ-020 IF_to_ID_Valid SHALL be IF_Valid && IF_ReadyGo && !br_taken. A taken branch cancels the wrong-path instruction currently in IF.
REQ-021 br_taken is sampled only when IF_Allow_in=1.
  - While decode stalls with br_taken held, the fetch of br_target SHALL occur on the first cycle ID_Allow_in=1.
  - No earlier fetch of br_target SHALL occur.
REQ-022 Instruction buffer inst_buf[31:0] with flag buf_valid:
  - Set: IF_Valid=1, ID_Allow_in=0, buf_valid=0 -> buf_valid<=1, inst_buf<=inst_sram_rdata.
  - Clear: buf_valid<=0 whenever IF_Allow_in=1.
  - Otherwise hold.
REQ-023 IF_to_ID_Bus[31:0] SHALL be inst_buf when buf_valid=1, else inst_sram_rdata. IF_to_ID_Bus[63:32] SHALL be IF_pc.
REQ-024 The instruction delivered to decode SHALL be identical regardless of SRAM rdata changes during a stall of any length.
REQ-025 Simultaneous br_taken=1 and ID_Allow_in=0 with IF_Valid=1:
  - IF_to_ID_Valid SHALL be 0.
  - IF_pc SHALL hold.
  - inst_sram_en SHALL be 0.
REQ-026 A handshake SHALL occur exactly when IF_to_ID_Valid && ID_Allow_in. Each fetched correct-path PC SHALL be delivered exactly once, in program order.

Reset
REQ-027 During reset:
  - IF_Valid=0, buf_valid=0, inst_buf=0, IF_pc=32'h1bfffffc.
  - IF_to_ID_Valid=0, inst_sram_en=0.
REQ-028 In the first cycle after reset deassertion, inst_sram_en SHALL be 1 and inst_sram_addr SHALL be 32'h1c000000.
REQ-029 Reset mid-operation SHALL discard any in-flight or buffered instruction. Fetch SHALL restart at 32'h1c000000.

Verification
REQ-030 Reset release, ID_Allow_in=1, rdata=32'h02800421 -> cycle 0: en=1, addr=1c000000; cycle 1: IF_to_ID_Valid=1, bus={1c000000,02800421}.
REQ-031 ID_Allow_in=1 held, no branch -> addr sequence 1c000000, 1c000004, 1c000008 on consecutive cycles; each PC delivered once.
REQ-032 IF holds pc 1c000008 with rdata=32'h00150004; drop ID_Allow_in for 3 cycles and change rdata to 32'hdeadbeef after the first stall cycle -> en=0 throughout; bus stays {1c000008,00150004}; on release addr=1c00000c.
REQ-033 IF pc 1c000010 valid, br_bus={1,1c000100} for one cycle, ID_Allow_in=1 -> that cycle IF_to_ID_Valid=0 and addr=1c000100; next cycle IF pc 1c000100 valid.
REQ-034 br_bus={1,1c000200} held while ID_Allow_in=0 for 2 cycles, then ID_Allow_in=1 -> no fetch for 2 cycles; on release addr=1c000200, IF_to_ID_Valid=0; next cycle pc 1c000200 valid.
REQ-035 Reset asserted while stalled with buf_valid=1 -> next cycle IF_to_ID_Valid=0 and buf_valid=0; first fetch after release at 1c000000.
